exc_sequencer: RTL

EXC_SEQUENCER -- requirements
Module: exc_sequencer

---
 rtl/exc_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/exc_sequencer.sv
// rtl/exc_sequencer.sv - exception/ERET flush-and-redirect sequencer
//
// Purpose: accepts an exception or an ERET in the exception stage. It squashes
//    the pipeline for FLUSH_CYCLES cycles and then issues a one-cycle PC
//    redirect, to the handler vector or to EPC.
//    It also synchronizes the external interrupt lines into the cause IP field.
//
// Ports:
//    clk            sole clock, rising edge
//    reset          synchronous, active-high reset
//    irq            asynchronous level interrupt requests (NUM_IRQ)
//    ext_cause_out  synchronized irq at bits [10 +: NUM_IRQ], zero elsewhere
//    exception_in   exception taken this cycle
//    eret_in        ERET decoded in the exception stage
//    pipe_stalled   exception stage stalled; blocks ERET acceptance
//    instr_pc       PC of instruction in the exception stage
//    epc_value      current EPC register contents
//    epc_out        PC to save into EPC (equal to instr_pc)
//    flush          squash all pipeline stages
//    busy           freeze fetch while a sequence is in progress
//    redirect_en    one-cycle PC load strobe
//    redirect_pc    PC load target (last latched target)
//    rfe_pulse      one-cycle status-stack pop request

module exc_sequencer #(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
   parameter int          FLUSH_CYCLES = 2,
   parameter int          NUM_IRQ      = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq,
   output logic [31:0]        ext_cause_out,
   input  logic               exception_in,
   input  logic               eret_in,
   input  logic               pipe_stalled,
   input  logic [31:0]        instr_pc,
   input  logic [31:0]        epc_value,
   output logic [31:0]        epc_out,
   output logic               flush,
   output logic               busy,
   output logic               redirect_en,
   output logic [31:0]        redirect_pc,
   output logic               rfe_pulse
);

   localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLUSH    = 2'd1,
      REDIRECT = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [3:0]         cnt;
   logic [31:0]        target;
   logic [NUM_IRQ-1:0] irq_meta;
   logic [NUM_IRQ-1:0] irq_sync;
   logic               load_exc;
   logic               load_eret;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         target   <= 32'd0;
         irq_meta <= '0;
         irq_sync <= '0;
      end else begin
         state    <= state_next;
         irq_meta <= irq;
         irq_sync <= irq_meta;
         if (load_exc) begin
            target <= EXC_VECTOR;
            cnt    <= FLUSH_INIT;
         end else if (load_eret) begin
            target <= epc_value;
            cnt    <= FLUSH_INIT;
         end else if (state == FLUSH) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   always_comb begin
      state_next  = state;
      load_exc    = 1'b0;
      load_eret   = 1'b0;
      flush       = 1'b0;
      busy        = 1'b0;
      redirect_en = 1'b0;
      rfe_pulse   = 1'b0;
      case (state)
         IDLE: begin
            // Exception wins over a simultaneous ERET; a stalled ERET waits.
            if (exception_in) begin
               load_exc   = 1'b1;
               state_next = FLUSH;
            end else if (eret_in && !pipe_stalled) begin
               load_eret  = 1'b1;
               rfe_pulse  = 1'b1;
               state_next = FLUSH;
            end
         end
         FLUSH: begin
            flush = 1'b1;
            busy  = 1'b1;
            // cnt holds the flush cycles remaining, including this one.
            if (cnt <= 4'd1) begin
               state_next = REDIRECT;
            end
         end
         REDIRECT: begin
            redirect_en = 1'b1;
            busy        = 1'b1;
            state_next  = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      // Reset overrides everything in the same cycle, including requests.
      if (reset) begin
         flush       = 1'b0;
         busy        = 1'b0;
         redirect_en = 1'b0;
         rfe_pulse   = 1'b0;
      end
   end

   always_comb begin
      ext_cause_out = 32'd0;
      if (!reset) begin
         ext_cause_out[10 +: NUM_IRQ] = irq_sync;
      end
   end

   assign redirect_pc = reset ? 32'd0 : target;
   assign epc_out     = instr_pc;

endmodule
